// File: rtl/idx_vec_decoder.sv
// Rebuilds an N-bit mask from a stream of bit indices (one-hot or thermometer per beat).
// Result registered 1 cycle after the last beat; in_ready stays low until the result is accepted.
module idx_vec_decoder #(
  parameter int N     = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_vec,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_err
);

  typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rdy;
  logic [N-1:0]     r_acc;
  logic [N-1:0]     r_vec;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_err;
  logic             r_out_err;

  logic             w_beat;
  logic             w_bad;
  logic [31:0]      w_idx;
  logic [N-1:0]     w_dec;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_idx     = 32'(in_idx);
  assign w_bad     = (w_idx >= 32'(N));
  assign w_beat    = in_valid && r_rdy;
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // Out-of-range indices contribute nothing to the vector, only to the error flag.
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < N; i++) begin
      if (in_mode ? (32'(i) <= w_idx) : (32'(i) == w_idx)) w_dec[i] = 1'b1;
    end
    if (w_bad) w_dec = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= (w_state_nxt == ST_ACCUM);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: if (w_beat && in_last) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready)         w_state_nxt = ST_ACCUM;
      default:                         w_state_nxt = ST_ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = r_rdy;
    out_valid = (r_state == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_vec     <= '0;
      r_out_cnt <= '0;
      r_out_err <= 1'b0;
    end else if (w_beat) begin
      if (in_last) begin
        r_vec     <= r_acc | w_dec;
        r_out_cnt <= w_cnt_inc;
        r_out_err <= r_err | w_bad;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_err     <= 1'b0;
      end else begin
        r_acc <= r_acc | w_dec;
        r_cnt <= w_cnt_inc;
        r_err <= r_err | w_bad;
      end
    end
  end

  assign out_vec = r_vec;
  assign out_cnt = r_out_cnt;
  assign out_err = r_out_err;

endmodule
